// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter sharing one dual_sram port among NPORT requesters.
// Supports bounded locked bursts and routes read data back via a tag pipeline.
module sram_port_arbiter #(
    parameter int unsigned NPORT    = 4,
    parameter int unsigned DWIDTH   = 32,
    parameter int unsigned AWIDTH   = 15,
    parameter int unsigned RD_LAT   = 1,
    parameter int unsigned MAX_LOCK = 16
) (
    input  logic                    clk_in,
    input  logic                    rst_n_in,
    input  logic [NPORT-1:0]        req_in,
    input  logic [NPORT-1:0]        we_in,
    input  logic [NPORT-1:0]        lock_in,
    input  logic [NPORT*AWIDTH-1:0] addr_in,
    input  logic [NPORT*DWIDTH-1:0] wdata_in,
    output logic [NPORT-1:0]        gnt_out,
    output logic [NPORT-1:0]        rd_valid_out,
    output logic [DWIDTH-1:0]       rd_data_out,
    output logic                    en_out,
    output logic                    we_out,
    output logic [AWIDTH-1:0]       addr_out,
    output logic [DWIDTH-1:0]       d_out,
    input  logic [DWIDTH-1:0]       d_in
);
    localparam int unsigned PW   = (NPORT > 1) ? $clog2(NPORT) : 1;
    localparam int unsigned CW   = $clog2(MAX_LOCK) + 1;
    localparam int unsigned LAST = NPORT - 1;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_t;

    state_t          state;
    logic [PW-1:0]   rr_ptr;
    logic [PW-1:0]   owner;
    logic [CW-1:0]   lock_cnt;
    logic [PW-1:0]   win_c;
    logic [PW-1:0]   idx_c;
    logic [PW-1:0]   next_c;
    logic            win_vld_c;
    logic            release_c;

    // Stage 0 is aligned with the issue register; RD_LAT further stages
    // line the tag up with d_in.
    logic [RD_LAT:0] tag_vld;
    logic [PW-1:0]   tag_port [0:RD_LAT];

    // Winner select: locked owner only, else first requester at/after rr_ptr.
    always_comb begin
        win_c     = owner;
        win_vld_c = 1'b0;
        idx_c     = '0;
        if (state == LOCK) begin
            win_vld_c = req_in[owner];
        end else begin
            for (int k = NPORT - 1; k >= 0; k--) begin
                idx_c = PW'((int'(rr_ptr) + k) % NPORT);
                if (req_in[idx_c]) begin
                    win_c     = idx_c;
                    win_vld_c = 1'b1;
                end
            end
        end
    end

    assign next_c    = (win_c == PW'(LAST)) ? '0 : win_c + PW'(1);
    assign release_c = (state == LOCK) && win_vld_c &&
                       (!lock_in[owner] || (lock_cnt == CW'(MAX_LOCK - 1)));
    assign gnt_out   = (win_vld_c && rst_n_in) ? (NPORT'(1) << win_c) : '0;

    // Arbitration state: pointer, lock owner and burst length.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            owner    <= '0;
            lock_cnt <= '0;
        end else if (win_vld_c) begin
            case (state)
                IDLE: begin
                    rr_ptr <= next_c;
                    if (lock_in[win_c]) begin
                        state    <= LOCK;
                        owner    <= win_c;
                        lock_cnt <= CW'(1);
                    end
                end
                LOCK: begin
                    if (release_c) begin
                        state    <= IDLE;
                        rr_ptr   <= next_c;
                        lock_cnt <= '0;
                    end else begin
                        lock_cnt <= lock_cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Issue register, tag pipeline and read return.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            en_out       <= 1'b0;
            we_out       <= 1'b0;
            addr_out     <= '0;
            d_out        <= '0;
            rd_valid_out <= '0;
            rd_data_out  <= '0;
            tag_vld      <= '0;
            for (int s = 0; s <= RD_LAT; s++) begin
                tag_port[s] <= '0;
            end
        end else begin
            en_out <= win_vld_c;
            we_out <= win_vld_c & we_in[win_c];
            if (win_vld_c) begin
                addr_out <= addr_in[win_c*AWIDTH +: AWIDTH];
                d_out    <= wdata_in[win_c*DWIDTH +: DWIDTH];
            end
            tag_vld[0]  <= win_vld_c & ~we_in[win_c];
            tag_port[0] <= win_c;
            for (int s = 1; s <= RD_LAT; s++) begin
                tag_vld[s]  <= tag_vld[s-1];
                tag_port[s] <= tag_port[s-1];
            end
            rd_valid_out <= tag_vld[RD_LAT] ? (NPORT'(1) << tag_port[RD_LAT]) : '0;
            if (tag_vld[RD_LAT]) begin
                rd_data_out <= d_in;
            end
        end
    end

endmodule
